// File: rtl/unified_mem_responder.sv
// Fixed-latency line memory behind a cache controller: accepts one read or
// write (eviction) at a time and answers with a one-cycle rdy pulse LAT cycles later.
module unified_mem_responder #(
    parameter int LAT = 4,
    parameter int AW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata,
    output logic          rdy,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(LAT - 2);

    state_t          state_r;
    logic [2:0]      cnt_r;
    logic [AW-1:0]   addr_r;
    logic [63:0]     wdata_r;
    logic            op_wr_r;
    logic            commit_s;
    logic [63:0]     mem_r [2**AW];

    // The op lands on the edge that moves BUSY into DONE.
    assign commit_s = (state_r == BUSY) && (cnt_r == 3'd0);

    // Request sequencer: owns state, countdown, latched request and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            addr_r  <= '0;
            wdata_r <= 64'h0;
            op_wr_r <= 1'b0;
            rdata   <= 64'h0;
            rdy     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rdy <= 1'b0;
                    if (re || we) begin
                        // A simultaneous read+write is serviced as a write only.
                        addr_r  <= addr;
                        wdata_r <= wdata;
                        op_wr_r <= we;
                        cnt_r   <= CNT_LOAD;
                        state_r <= BUSY;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_r == 3'd0) begin
                        state_r <= DONE;
                        rdy     <= 1'b1;
                        if (!op_wr_r) begin
                            rdata <= mem_r[addr_r];
                        end else begin
                            rdata <= rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                DONE: begin
                    // Requests still held here wait for the next IDLE cycle.
                    state_r <= IDLE;
                    rdy     <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 3'd0;
                    rdy     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Line storage: deliberately not reset; only completed writes modify it.
    always_ff @(posedge clk) begin
        if (commit_s && op_wr_r) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

endmodule
